// File: rtl/tq_pkg.sv
// Shared constants and helpers for the forward integer transform datapath.
package tq_pkg;

    localparam logic [1:0] SIZE_4  = 2'd0;
    localparam logic [1:0] SIZE_8  = 2'd1;
    localparam logic [1:0] SIZE_16 = 2'd2;
    localparam logic [1:0] SIZE_32 = 2'd3;

    // Lane count for a size code, clamped to the number of physical lanes.
    function automatic int unsigned size_to_n(input logic [1:0] code, input int unsigned n_max);
        int unsigned n;
        n = 32'd4 << code;
        return (n > n_max) ? n_max : n;
    endfunction

    // Bit offset of lane j in a flat bus of w-bit lanes.
    function automatic int lane_lsb(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/butterfly_lane_comb.sv
// Combinational first-stage butterfly over all lanes for the selected size, or sign-extended pass-through.
module butterfly_lane_comb
    import tq_pkg::*;
#(
    parameter int unsigned IN_W  = 17,
    parameter int unsigned N_MAX = 32
) (
    input  logic [N_MAX*IN_W-1:0]     data,
    input  logic [1:0]                size,
    input  logic                      enable,
    output logic [N_MAX*(IN_W+1)-1:0] result_c
);

    localparam int unsigned OW = IN_W + 1;

    for (genvar j = 0; j < int'(N_MAX); j++) begin : g_lane
        logic signed [IN_W-1:0]  self;
        logic [3:0][OW-1:0]      by_size;
        logic signed [OW-1:0]    lane_out;

        assign self = data[lane_lsb(j, int'(IN_W)) +: IN_W];

        // Per-size candidate: mirror partner is the constant lane N-1-j.
        for (genvar s = 0; s < 4; s++) begin : g_size
            localparam int N = int'(size_to_n(2'(s), N_MAX));
            if (j < N / 2) begin : g_sum
                logic signed [IN_W-1:0] mirror;
                assign mirror     = data[lane_lsb(N - 1 - j, int'(IN_W)) +: IN_W];
                assign by_size[s] = OW'(self) + OW'(mirror);
            end else if (j < N) begin : g_diff
                logic signed [IN_W-1:0] mirror;
                assign mirror     = data[lane_lsb(N - 1 - j, int'(IN_W)) +: IN_W];
                assign by_size[s] = OW'(mirror) - OW'(self);
            end else begin : g_pass
                assign by_size[s] = OW'(self);
            end
        end

        assign lane_out = enable ? by_size[size] : OW'(self);
        assign result_c[lane_lsb(j, int'(OW)) +: OW] = lane_out;
    end

endmodule

// File: rtl/butterfly_stage_pipe.sv
// Pipelined first-stage butterfly: valid/ready handshake, output register, block row counter and size/enable latch.
module butterfly_stage_pipe
    import tq_pkg::*;
#(
    parameter int unsigned IN_W  = 17,
    parameter int unsigned N_MAX = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    output logic                      i_ready,
    input  logic                      i_enable,
    input  logic [1:0]                i_size,
    input  logic [N_MAX*IN_W-1:0]     i_data,
    output logic                      o_valid,
    input  logic                      o_ready,
    output logic [N_MAX*(IN_W+1)-1:0] o_data,
    output logic                      o_last,
    output logic [1:0]                o_size
);

    localparam int unsigned OUT_W = N_MAX * (IN_W + 1);

    logic [CNT_W-1:0] row_cnt, row_cnt_n;
    logic [1:0]       size_q, size_q_n;
    logic             en_q, en_q_n;
    logic             o_valid_n, o_last_n;
    logic [OUT_W-1:0] o_data_n;
    logic [1:0]       o_size_n;

    logic             accept;
    logic             first_row;
    logic [1:0]       size_eff;
    logic             en_eff;
    logic             last_c;
    logic [OUT_W-1:0] bfly_c;

    assign i_ready = !o_valid || o_ready;

    butterfly_lane_comb #(
        .IN_W  (IN_W),
        .N_MAX (N_MAX)
    ) u_lanes (
        .data     (i_data),
        .size     (size_eff),
        .enable   (en_eff),
        .result_c (bfly_c)
    );

    // The first row of a block takes size/enable from the inputs; later rows use the held copy.
    always_comb begin
        accept    = i_valid && i_ready;
        first_row = (row_cnt == '0);
        size_eff  = first_row ? i_size   : size_q;
        en_eff    = first_row ? i_enable : en_q;
        last_c    = (row_cnt == CNT_W'(size_to_n(size_eff, N_MAX) - 1));
    end

    always_comb begin
        row_cnt_n = row_cnt;
        size_q_n  = size_q;
        en_q_n    = en_q;
        o_valid_n = o_valid;
        o_data_n  = o_data;
        o_last_n  = o_last;
        o_size_n  = o_size;
        if (accept) begin
            o_valid_n = 1'b1;
            o_data_n  = bfly_c;
            o_last_n  = last_c;
            o_size_n  = size_eff;
            size_q_n  = size_eff;
            en_q_n    = en_eff;
            row_cnt_n = last_c ? '0 : row_cnt + CNT_W'(1);
        end else if (o_ready) begin
            o_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt <= '0;
            size_q  <= '0;
            en_q    <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
            o_size  <= '0;
        end else begin
            row_cnt <= row_cnt_n;
            size_q  <= size_q_n;
            en_q    <= en_q_n;
            o_valid <= o_valid_n;
            o_data  <= o_data_n;
            o_last  <= o_last_n;
            o_size  <= o_size_n;
        end
    end

endmodule

// File: tb/tb_butterfly_stage_pipe.sv
// Directed self-checking bench for butterfly_stage_pipe (IN_W=17, N_MAX=32).
module tb_butterfly_stage_pipe;
    import tq_pkg::*;

    localparam int IN_W  = 17;
    localparam int N_MAX = 32;
    localparam int CNT_W = 5;
    localparam int OW    = IN_W + 1;

    logic                    clk;
    logic                    rst;
    logic                    i_valid;
    logic                    i_ready;
    logic                    i_enable;
    logic [1:0]              i_size;
    logic [N_MAX*IN_W-1:0]   i_data;
    logic                    o_valid;
    logic                    o_ready;
    logic [N_MAX*OW-1:0]     o_data;
    logic                    o_last;
    logic [1:0]              o_size;

    logic [N_MAX*IN_W-1:0]   din;
    int                      n_checks;
    int                      n_fail;

    butterfly_stage_pipe #(
        .IN_W  (IN_W),
        .N_MAX (N_MAX),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_enable (i_enable),
        .i_size   (i_size),
        .i_data   (i_data),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_data   (o_data),
        .o_last   (o_last),
        .o_size   (o_size)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint lane(input int j);
        logic signed [OW-1:0] t;
        t = o_data[j*OW +: OW];
        return longint'(t);
    endfunction

    task automatic set_lane(input int j, input longint v);
        din[j*IN_W +: IN_W] = IN_W'(v);
    endtask

    task automatic set_uniform(input longint v);
        for (int j = 0; j < N_MAX; j++) set_lane(j, v);
    endtask

    // Present one row, expect it to be accepted at the next edge, sample #1 after.
    task automatic send_row(input logic [1:0] sz, input logic en);
        i_size   = sz;
        i_enable = en;
        i_data   = din;
        i_valid  = 1'b1;
        check("i_ready_before_send", longint'(i_ready), 1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        i_valid  = 1'b0;
        i_enable = 1'b0;
        i_size   = 2'd0;
        i_data   = '0;
        o_ready  = 1'b1;
        din      = '0;
        n_checks = 0;
        n_fail   = 0;

        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_o_valid", longint'(o_valid), 0);
        check("rst_o_last",  longint'(o_last), 0);
        check("rst_o_size",  longint'(o_size), 0);
        check("rst_o_data",  longint'(o_data == '0), 1);
        check("rst_i_ready", longint'(i_ready), 1);

        // Size 16 butterfly, lanes 16..31 pass through as -1.
        din = '0;
        for (int j = 0; j < 16; j++) set_lane(j, j);
        for (int j = 16; j < 32; j++) set_lane(j, -1);
        send_row(SIZE_16, 1'b1);
        check("t1_valid", longint'(o_valid), 1);
        for (int j = 0; j < 8; j++)   check($sformatf("t1_lane%0d", j), lane(j), 15);
        for (int j = 8; j < 16; j++)  check($sformatf("t1_lane%0d", j), lane(j), -(2*(j-8)+1));
        for (int j = 16; j < 32; j++) check($sformatf("t1_lane%0d", j), lane(j), -1);
        check("t1_last", longint'(o_last), 0);
        check("t1_size", longint'(o_size), 2);
        do_reset();
        check("t1_rst_valid", longint'(o_valid), 0);

        // Size 4, four back-to-back rows at the extremes of the input range.
        din = '0;
        set_lane(0, 65535);
        set_lane(1, -65536);
        set_lane(2, 1);
        set_lane(3, 2);
        for (int r = 0; r < 4; r++) begin
            send_row(SIZE_4, 1'b1);
            check($sformatf("t2_r%0d_l0", r), lane(0), 65537);
            check($sformatf("t2_r%0d_l1", r), lane(1), -65535);
            check($sformatf("t2_r%0d_l2", r), lane(2), -65537);
            check($sformatf("t2_r%0d_l3", r), lane(3), 65533);
            check($sformatf("t2_r%0d_l4", r), lane(4), 0);
            check($sformatf("t2_r%0d_last", r), longint'(o_last), (r == 3) ? 1 : 0);
            check($sformatf("t2_r%0d_size", r), longint'(o_size), 0);
        end

        // Size 8 pass-through; counter wrapped, so size is sampled afresh.
        for (int j = 0; j < N_MAX; j++) set_lane(j, -j);
        for (int r = 0; r < 8; r++) begin
            send_row(SIZE_8, 1'b0);
            check($sformatf("t3_r%0d_l0", r), lane(0), 0);
            check($sformatf("t3_r%0d_l7", r), lane(7), -7);
            check($sformatf("t3_r%0d_l31", r), lane(31), -31);
            check($sformatf("t3_r%0d_size", r), longint'(o_size), 1);
            check($sformatf("t3_r%0d_last", r), longint'(o_last), (r == 7) ? 1 : 0);
        end

        // Size 32 with a 3-cycle downstream stall after row 10.
        for (int r = 1; r <= 32; r++) begin
            set_uniform(r);
            if (r == 11) begin
                o_ready  = 1'b0;
                i_data   = din;
                i_size   = SIZE_32;
                i_enable = 1'b1;
                i_valid  = 1'b1;
                #1;
                check("t4_stall_ready0", longint'(i_ready), 0);
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk);
                    #1;
                    check($sformatf("t4_stall%0d_ready", k), longint'(i_ready), 0);
                    check($sformatf("t4_stall%0d_valid", k), longint'(o_valid), 1);
                    check($sformatf("t4_stall%0d_l0", k), lane(0), 20);
                    check($sformatf("t4_stall%0d_last", k), longint'(o_last), 0);
                end
                o_ready = 1'b1;
                #1;
            end
            send_row(SIZE_32, 1'b1);
            check($sformatf("t4_r%0d_l0", r), lane(0), 2*r);
            check($sformatf("t4_r%0d_l20", r), lane(20), 0);
            check($sformatf("t4_r%0d_last", r), longint'(o_last), (r == 32) ? 1 : 0);
        end

        // Size code change mid-block is ignored until the block closes.
        for (int r = 1; r <= 16; r++) begin
            set_uniform(r);
            send_row((r < 5) ? SIZE_16 : SIZE_4, 1'b1);
            check($sformatf("t5_r%0d_size", r), longint'(o_size), 2);
            check($sformatf("t5_r%0d_l5", r), lane(5), 2*r);
            check($sformatf("t5_r%0d_l20", r), lane(20), r);
            check($sformatf("t5_r%0d_last", r), longint'(o_last), (r == 16) ? 1 : 0);
        end
        for (int r = 1; r <= 4; r++) begin
            set_uniform(100 + r);
            send_row(SIZE_4, 1'b1);
            check($sformatf("t5b_r%0d_size", r), longint'(o_size), 0);
            check($sformatf("t5b_r%0d_l0", r), lane(0), 2*(100 + r));
            check($sformatf("t5b_r%0d_l5", r), lane(5), 100 + r);
            check($sformatf("t5b_r%0d_last", r), longint'(o_last), (r == 4) ? 1 : 0);
        end

        // Reset on row 3 of an 8-row block discards the partial block.
        for (int r = 1; r <= 2; r++) begin
            set_uniform(r);
            send_row(SIZE_8, 1'b1);
        end
        set_uniform(3);
        i_data   = din;
        i_size   = SIZE_8;
        i_enable = 1'b1;
        i_valid  = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        i_valid = 1'b0;
        check("t6_rst_valid", longint'(o_valid), 0);
        check("t6_rst_l0", lane(0), 0);
        for (int r = 1; r <= 8; r++) begin
            set_uniform(10 + r);
            send_row(SIZE_8, 1'b1);
            check($sformatf("t6_r%0d_l0", r), lane(0), 2*(10 + r));
            check($sformatf("t6_r%0d_l5", r), lane(5), 0);
            check($sformatf("t6_r%0d_last", r), longint'(o_last), (r == 8) ? 1 : 0);
        end

        @(posedge clk);
        #1;
        check("end_valid_drops", longint'(o_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
